// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Function : Raster timing generator (x/y, frame_active, line/frame pulses,
//            delayed hsync/vsync). Define FRAME_COUNTER_EN for frame_count.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_H_LAST     = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST     = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_bad_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..3");
    end
  endgenerate

  logic       r_running;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       w_hsync_raw;
  logic       w_vsync_raw;
  logic       w_wrap;

  // Counters hold at (0,0) for the first edge so that position is visible
  // as a full clock with running=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b0;
      r_h_cnt   <= 10'd0;
      r_v_cnt   <= 10'd0;
    end else if (!r_running) begin
      r_running <= 1'b1;
    end else if (r_h_cnt == c_H_LAST) begin
      r_h_cnt <= 10'd0;
      if (r_v_cnt == c_V_LAST) begin
        r_v_cnt <= 10'd0;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign w_wrap       = r_running && (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_LAST);
  assign x            = r_h_cnt;
  assign y            = r_v_cnt;
  assign frame_active = r_running && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign line_start   = r_running && (r_h_cnt == 10'd0);
  assign frame_start  = r_running && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  assign w_hsync_raw = ((r_h_cnt >= c_HS_START) && (r_h_cnt <= c_HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign w_vsync_raw = ((r_v_cnt >= c_VS_START) && (r_v_cnt <= c_VS_END)) ? SYNC_POL : ~SYNC_POL;

  generate
    if (SYNC_DELAY == 0) begin : g_sync_direct
      assign hsync = w_hsync_raw;
      assign vsync = w_vsync_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] r_hs_pipe;
      logic [SYNC_DELAY-1:0] r_vs_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_hs_pipe <= {SYNC_DELAY{~SYNC_POL}};
          r_vs_pipe <= {SYNC_DELAY{~SYNC_POL}};
        end else begin
          r_hs_pipe[0] <= w_hsync_raw;
          r_vs_pipe[0] <= w_vsync_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            r_hs_pipe[i] <= r_hs_pipe[i-1];
            r_vs_pipe[i] <= r_vs_pipe[i-1];
          end
        end
      end

      assign hsync = r_hs_pipe[SYNC_DELAY-1];
      assign vsync = r_vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

`ifdef FRAME_COUNTER_EN
  logic [7:0] r_frame_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_count <= 8'd0;
    end else if (w_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  logic w_unused;
  assign w_unused = w_wrap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// Self-checking bench for vga_timing_gen: small raster geometry, arithmetic
// position model, random asynchronous resets.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int D  = 1;
  localparam bit POL = 1'b0;
  localparam int HT = HA + HF + HS + HB;   // 16
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FR = HT * VT;             // 160

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] x, y;
  logic       frame_active, hsync, vsync, line_start, frame_start;
`ifdef FRAME_COUNTER_EN
  logic [7:0] frame_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int k     = 0;   // clock edges since reset release
  bit chk_en = 1'b0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .SYNC_DELAY(D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .x            (x),
    .y            (y),
    .frame_active (frame_active),
    .hsync        (hsync),
    .vsync        (vsync),
    .line_start   (line_start),
    .frame_start  (frame_start)
`ifdef FRAME_COUNTER_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raw sync level of the raster state reached after edge j (j<1: idle at 0,0)
  function automatic bit sync_raw(input int j, input bit horiz);
    int pos, h, v;
    if (j < 1) return ~POL;
    pos = (j - 1) % FR;
    h = pos % HT;
    v = pos / HT;
    if (horiz) return (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
    return (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
  endfunction

  always @(negedge clk) begin : cmp
    int pos;
    if (chk_en) begin
      pos = (k > 0) ? (k - 1) % FR : 0;
      check("x",            int'(x),            pos % HT);
      check("y",            int'(y),            pos / HT);
      check("frame_active", int'(frame_active), int'(k > 0 && (pos % HT) < HA && (pos / HT) < VA));
      check("line_start",   int'(line_start),   int'(k > 0 && (pos % HT) == 0));
      check("frame_start",  int'(frame_start),  int'(k > 0 && pos == 0));
      check("hsync",        int'(hsync),        int'(sync_raw(k - D, 1'b1)));
      check("vsync",        int'(vsync),        int'(sync_raw(k - D, 1'b0)));
`ifdef FRAME_COUNTER_EN
      check("frame_count",  int'(frame_count),  (k > 0) ? ((k - 1) / FR) % 256 : 0);
`endif
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_x"},  int'(x), 0);
    check({tag, "_y"},  int'(y), 0);
    check({tag, "_fa"}, int'(frame_active), 0);
    check({tag, "_ls"}, int'(line_start), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_hs"}, int'(hsync), 1);
    check({tag, "_vs"}, int'(vsync), 1);
  endtask

  initial begin
    int first_lo, last_lo, n_lo, t0, t1, n_ls, n_vs, vs_x, vs_y;
    bit seen;

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (10) @(posedge clk);
    #1 check_reset_state("rst");

    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_fa", int'(frame_active), 1);
    check("first_fs", int'(frame_start), 1);
    check("first_ls", int'(line_start), 1);
    check("first_x",  int'(x), 0);
    check("first_y",  int'(y), 0);

    // One line: hsync low window in x coordinates, one clock late
    first_lo = -1; last_lo = -1; n_lo = 0;
    for (int i = 0; i < HT; i++) begin
      @(negedge clk);
      if (hsync == 1'b0) begin
        if (first_lo < 0) first_lo = int'(x);
        last_lo = int'(x);
        n_lo++;
      end
    end
    check("hs_first_x", first_lo, 11);
    check("hs_last_x",  last_lo, 13);
    check("hs_width",   n_lo, 3);

    // Frame period, line pulses and vsync width between two frame_starts
    t0 = -1; t1 = -1; n_ls = 0; n_vs = 0; vs_x = -1; vs_y = -1;
    for (int i = 0; i < 2 * FR + HT; i++) begin
      @(negedge clk);
      if (frame_start) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
      if (t0 >= 0 && t1 < 0) begin
        if (line_start) n_ls++;
        if (vsync == 1'b0) begin
          if (vs_x < 0) begin vs_x = int'(x); vs_y = int'(y); end
          n_vs++;
        end
      end
    end
    check("frame_period", t1 - t0, 160);
    check("line_pulses",  n_ls, 10);
    check("vs_width",     n_vs, 32);
    check("vs_start_x",   vs_x, 1);
    check("vs_start_y",   vs_y, 7);

    // Explicit wrap from the last position back to origin
    seen = 1'b0;
    for (int i = 0; i < FR + 2 && !seen; i++) begin
      @(negedge clk);
      if (int'(x) == HT - 1 && int'(y) == VT - 1) seen = 1'b1;
    end
    check("wrap_seen", int'(seen), 1);
    @(posedge clk);
    #1;
    check("wrap_x",  int'(x), 0);
    check("wrap_y",  int'(y), 0);
    check("wrap_fs", int'(frame_start), 1);

    // Random asynchronous resets mid-frame
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(1, 400)) @(posedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b0;
      #1 check_reset_state("async");
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("restart_x",  int'(x), 0);
      check("restart_y",  int'(y), 0);
      check("restart_fs", int'(frame_start), 1);
    end

`ifdef FRAME_COUNTER_EN
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("fc_start", int'(frame_count), 0);
    repeat (FR - 1) @(posedge clk);
    #1 check("fc_before_wrap", int'(frame_count), 0);
    @(posedge clk);
    #1 check("fc_first_wrap", int'(frame_count), 1);
    repeat (255 * FR) @(posedge clk);
    #1 check("fc_256_wraps", int'(frame_count), 0);
`endif

    repeat (20) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator directly upstream of graphics_engine.
- Produces the pixel coordinates x/y and frame_active that the engine consumes, plus hsync/vsync for the VGA pins.
- Sync outputs are delayed by a configurable number of stages to line up with the registered RGB path downstream.
- Default timing is 640x480@60 with a 25.175 MHz clk.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- SYNC_DELAY, 1, register stages on hsync/vsync (0..3)

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- x  output  10  horizontal counter h_cnt
- y  output  10  vertical counter v_cnt
- frame_active  output  1  running & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE
- hsync  output  1  horizontal sync, SYNC_DELAY stages late
- vsync  output  1  vertical sync, SYNC_DELAY stages late
- line_start  output  1  one-clock pulse when h_cnt==0 (running only)
- frame_start  output  1  one-clock pulse when h_cnt==0 and v_cnt==0 (running only)
- frame_count  output  8  completed-frame counter (present only with FRAME_COUNTER_EN)

Behaviour:
- One clock domain; reset is asynchronous and active-low, on clk and rst_n.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - Both must be ≤1024; a simulation-time check reports an error otherwise.
- State: running flag, h_cnt[9:0], v_cnt[9:0], SYNC_DELAY-deep shift registers for hsync/vsync.
- Reset values:
  - running=0, h_cnt=0, v_cnt=0.
  - x=0, y=0, frame_active=0, line_start=0, frame_start=0.
  - hsync=vsync=~SYNC_POL (deasserted), every delay stage also ~SYNC_POL.
  - frame_count=0.
- First edge after reset release: running←1; counters hold at 0. From then on x=0, y=0, frame_active=1, line_start=1, frame_start=1.
- Each later edge (running=1):
  - h_cnt increments.
  - At h_cnt==H_TOTAL-1: h_cnt←0 and v_cnt increments.
  - At v_cnt==V_TOTAL-1 together with the h wrap: v_cnt←0.
- x, y, frame_active, line_start and frame_start are combinational from registered state. Latency is 0 relative to the counters.
- Raw sync intervals (inclusive):
  - hsync_raw = SYNC_POL when h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync_raw = SYNC_POL when v_cnt ∈ [490,491], asserted for the whole line including blanking.
- hsync/vsync equal the raw values delayed by SYNC_DELAY clocks. With SYNC_DELAY=0 they are combinational.
- Wrap-around: the (799,524)→(0,0) transition takes one clock; no extra idle cycle.
- Mid-operation reset: all state returns to reset values immediately (asynchronous); restart follows the first-edge rule.
- No inputs besides clk and rst_n, so there are no simultaneous-event cases.

Optional Feature:
- Macro: FRAME_COUNTER_EN.
- Defined:
  - frame_count[7:0] port exists, reset 0.
  - Increments on the edge where (h_cnt,v_cnt) wraps from (799,524) to (0,0).
  - Wraps 255→0.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset held 10 clocks → x=0, y=0, frame_active=0, hsync=vsync=1, line_start=frame_start=0. First edge after release → frame_active=1, frame_start=1, x=0.
- Run one line, SYNC_DELAY=1 → x reaches 639 with frame_active=1; x=640 gives frame_active=0. hsync is low for exactly 96 clocks, first low while x==657, last low while x==752.
- Run a full frame → frame_active stays 0 for y 480..524. vsync is low for 2×800 clocks, starting one clock after (x=0, y=490). Next frame_start occurs exactly 420000 clocks after the first.
- Observe the wrap at (799,524) → the next clock shows x=0, y=0, frame_start=1. line_start pulses once per 800 clocks.
- Assert rst_n at (x=300, y=200) mid-frame → outputs go to reset values without waiting for clk. After release, timing restarts from (0,0).
- FRAME_COUNTER_EN defined, run 256 frames → frame_count steps 0→1 at the first wrap and reads 0 after the 256th wrap.
